// File: rtl/soc_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the canonical NOP used for fault responses and the AXI OKAY code.
package soc_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE,
        IFU_ADDR,
        IFU_DATA,
        IFU_RESP
    } ifu_state_t;

    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifu_if.sv
// Fetch request/response and AXI4-Lite read channel bundle for the IFU.
//
// Handshake semantics: a transfer on the AR channel happens on a rising clock
// edge where arvalid && arready; a transfer on the R channel happens on an edge
// where rvalid && rready. Once a valid is raised, it and its payload stay
// stable until the transfer. ifu_reqValid and ifu_respValid are single-cycle
// pulses with no back-pressure; pc is meaningful only while ifu_reqValid is
// high, inst/ifu_fault are meaningful when ifu_respValid is high and are held
// between responses.
interface ifu_if #(
    parameter int ADDR_W = 32
);
    logic              ifu_reqValid;
    logic [ADDR_W-1:0] pc;
    logic              ifu_respValid;
    logic [31:0]       inst;
    logic              ifu_fault;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    // IFU side of the bundle
    modport slave (
        input  ifu_reqValid, pc, arready, rdata, rresp, rvalid,
        output ifu_respValid, inst, ifu_fault, araddr, arvalid, rready
    );

    // Sequencer plus bus slave side of the bundle
    modport master (
        output ifu_reqValid, pc, arready, rdata, rresp, rvalid,
        input  ifu_respValid, inst, ifu_fault, araddr, arvalid, rready
    );
endinterface

// File: rtl/ifu_perf.sv
// Performance counters for the IFU: completed responses and cycles spent
// waiting on the bus. Both wrap at 2^32.
module ifu_perf (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_done,
    input  logic        stall,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Next counter values: bump on each event, natural wrap.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_done) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (stall)      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch request -> one AXI4-Lite read at pc ->
// one registered response pulse with the fetched word or a fault.
// Optional feature: define IFU_PERF_EN to add perf_fetch_cnt/perf_stall_cnt.
module ifu
    import soc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset,
    ifu_if.slave        bus,
    output ifu_state_t  dbg_state
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    // Counter value seen in the last allowed wait cycle; 0 disables timeout.
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       inst_q, inst_d;
    logic              fault_q, fault_d;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic              timed_out;

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_valid_d = 1'b0;
        inst_d       = inst_q;
        fault_d      = fault_q;
        tmo_cnt_d    = tmo_cnt_q;
        timed_out    = (TIMEOUT_CYC != 0) && (tmo_cnt_q >= TMO_LAST);

        case (state_q)
            IFU_IDLE: begin
                if (bus.ifu_reqValid) begin
                    if (bus.pc[1:0] != 2'b00) begin
                        // Misaligned: fault straight away, no bus access.
                        state_d      = IFU_RESP;
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                        inst_d       = INST_NOP;
                    end else begin
                        state_d   = IFU_ADDR;
                        araddr_d  = bus.pc;
                        arvalid_d = 1'b1;
                        tmo_cnt_d = '0;
                    end
                end
            end
            IFU_ADDR: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                // A completed handshake is honoured even in the last wait cycle.
                if (arvalid_q && bus.arready) begin
                    state_d   = IFU_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (timed_out) begin
                    state_d      = IFU_RESP;
                    arvalid_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    fault_d      = 1'b1;
                    inst_d       = INST_NOP;
                end
            end
            IFU_DATA: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (rready_q && bus.rvalid) begin
                    state_d      = IFU_RESP;
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    fault_d      = (bus.rresp != AXI_RESP_OKAY);
                    inst_d       = (bus.rresp != AXI_RESP_OKAY) ? INST_NOP : bus.rdata;
                end else if (timed_out) begin
                    // Dropping rready makes any late rvalid harmless.
                    state_d      = IFU_RESP;
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    fault_d      = 1'b1;
                    inst_d       = INST_NOP;
                end
            end
            IFU_RESP: begin
                state_d = IFU_IDLE;
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IFU_IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            inst_q       <= INST_NOP;
            fault_q      <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
            inst_q       <= inst_d;
            fault_q      <= fault_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.araddr        = araddr_q;
    assign bus.arvalid       = arvalid_q;
    assign bus.rready        = rready_q;
    assign bus.ifu_respValid = resp_valid_q;
    assign bus.inst          = inst_q;
    assign bus.ifu_fault     = fault_q;
    assign dbg_state         = state_q;

`ifdef IFU_PERF_EN
    ifu_perf u_perf (
        .clock          (clock),
        .reset          (reset),
        .fetch_done     (resp_valid_q),
        .stall          ((state_q == IFU_ADDR) || (state_q == IFU_DATA)),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed corner cases plus randomized fetches against a
// latency/result reference model; responses are checked by a scoreboard.
module tb_ifu;
    import soc_pkg::*;

    localparam int T = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    ifu_if #(.ADDR_W(32)) bus ();
    ifu_state_t dbg_state;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    ifu #(.ADDR_W(32), .TIMEOUT_CYC(T)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {expected response cycle[64:33], fault[32], inst[31:0]}
    logic [64:0] exp_q[$];
    int checks = 0;
    int fails = 0;
    int resp_cnt = 0;
    int exp_fetch = 0;
    int exp_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: result and response cycle from the fetch rules.
    function automatic logic [64:0] model(input logic [31:0] pc, input int ar_wait,
                                          input int r_wait, input logic [31:0] rdata,
                                          input logic [1:0] rresp, input int req_cyc);
        int k;
        if (pc[1:0] != 2'b00) return {32'(req_cyc + 1), 1'b1, INST_NOP};
        k = (ar_wait + 1) + (r_wait + 1);
        if (k <= T) begin
            if (rresp != 2'b00) return {32'(req_cyc + 1 + k), 1'b1, INST_NOP};
            return {32'(req_cyc + 1 + k), 1'b0, rdata};
        end
        return {32'(req_cyc + 1 + T), 1'b1, INST_NOP};
    endfunction

    // Monitor: every response pulse is popped and compared.
    always @(negedge clock) begin
        if (!reset && bus.ifu_respValid) begin
            logic [64:0] e;
            resp_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_resp: got response inst %0h, none expected", bus.inst);
            end else begin
                e = exp_q.pop_front();
                check("resp_inst", 64'(bus.inst), 64'(e[31:0]));
                check("resp_fault", 64'(bus.ifu_fault), 64'(e[32]));
                check("resp_cycle", 64'(cyc), 64'(e[64:33]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_fetch(input logic [31:0] pc, input int ar_wait, input int r_wait,
                            input logic [31:0] rdata, input logic [1:0] rresp,
                            input bit extra_req);
        int target;
        int k;
        @(negedge clock);
        target = resp_cnt + 1;
        bus.ifu_reqValid = 1'b1;
        bus.pc = pc;
        exp_q.push_back(model(pc, ar_wait, r_wait, rdata, rresp, cyc));
        exp_fetch++;
        if (pc[1:0] == 2'b00) begin
            k = ar_wait + r_wait + 2;
            exp_stall += (k <= T) ? k : T;
        end
        @(negedge clock);
        bus.ifu_reqValid = 1'b0;
        bus.pc = $urandom;
        if (pc[1:0] != 2'b00) begin
            check("no_ar_misaligned", 64'(bus.arvalid), 64'd0);
        end else begin
            for (int i = 0; i <= ar_wait; i++) begin
                check("ar_valid_held", 64'(bus.arvalid), 64'd1);
                check("ar_addr_held", 64'(bus.araddr), 64'(pc));
                bus.arready = (i == ar_wait);
                @(negedge clock);
            end
            bus.arready = 1'b0;
            check("ar_single", 64'(bus.arvalid), 64'd0);
            if (extra_req) begin
                bus.ifu_reqValid = 1'b1;
                bus.pc = pc ^ 32'h0000_0100;
            end
            for (int j = 0; j <= r_wait; j++) begin
                bus.rvalid = (j == r_wait);
                if (j == r_wait) begin
                    bus.rdata = rdata;
                    bus.rresp = rresp;
                end
                @(negedge clock);
                bus.ifu_reqValid = 1'b0;
            end
            bus.rvalid = 1'b0;
            bus.rdata = $urandom;
            bus.rresp = 2'b00;
        end
        for (int w = 0; w < 40 && resp_cnt < target; w++) @(negedge clock);
        if (resp_cnt < target) begin
            checks++;
            fails++;
            $display("FAIL resp_wait: no response for pc %0h within 40 cycles", pc);
            exp_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    // Reset in the middle of a read: all bus/response outputs return to idle values.
    task automatic reset_in_data();
        @(negedge clock);
        bus.ifu_reqValid = 1'b1;
        bus.pc = 32'h8000_0100;
        @(negedge clock);
        bus.ifu_reqValid = 1'b0;
        bus.arready = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        check("pre_reset_rready", 64'(bus.rready), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_fetch = 0;
        exp_stall = 0;
        check("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check("rst_rready", 64'(bus.rready), 64'd0);
        check("rst_respvalid", 64'(bus.ifu_respValid), 64'd0);
        check("rst_inst", 64'(bus.inst), 64'(INST_NOP));
        check("rst_fault", 64'(bus.ifu_fault), 64'd0);
        repeat (3) @(negedge clock);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.ifu_reqValid = 1'b0;
        bus.pc = '0;
        bus.arready = 1'b0;
        bus.rdata = '0;
        bus.rresp = 2'b00;
        bus.rvalid = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_arvalid", 64'(bus.arvalid), 64'd0);
        check("reset_rready", 64'(bus.rready), 64'd0);
        check("reset_respvalid", 64'(bus.ifu_respValid), 64'd0);
        check("reset_fault", 64'(bus.ifu_fault), 64'd0);
        check("reset_inst", 64'(bus.inst), 64'(INST_NOP));
        check("reset_araddr", 64'(bus.araddr), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        do_fetch(32'h8000_0000, 0, 0, 32'h0000_0093, 2'b00, 1'b0);
        do_fetch(32'h8000_0004, 5, 0, 32'hDEAD_BEE3, 2'b00, 1'b0);
        do_fetch(32'h8000_0002, 0, 0, 32'h1111_1111, 2'b00, 1'b0);
        do_fetch(32'h8000_0008, 0, 1, 32'h0000_1234, 2'b10, 1'b0);
        do_fetch(32'h8000_000C, 1, 1, 32'h0040_0513, 2'b00, 1'b0);
        do_fetch(32'h8000_0010, 0, 10, 32'h5555_5555, 2'b00, 1'b0);
        do_fetch(32'h8000_0014, 0, 6, 32'h00A0_0093, 2'b00, 1'b0);
        do_fetch(32'h8000_0018, 1, 6, 32'h7777_7777, 2'b00, 1'b0);
        do_fetch(32'h8000_001C, 1, 2, 32'h0010_0113, 2'b00, 1'b1);
        do_fetch(32'h8000_0020, 0, 0, 32'hCAFE_F00D, 2'b00, 1'b0);
        reset_in_data();

        for (int n = 0; n < 60; n++) begin
            logic [31:0] pc;
            int ar_wait, r_wait;
            logic [1:0] rresp;
            pc = $urandom;
            if ($urandom_range(7, 0) != 0) pc[1:0] = 2'b00;
            ar_wait = $urandom_range(5, 0);
            r_wait = ($urandom_range(5, 0) == 0) ? $urandom_range(10, 6) : $urandom_range(3, 0);
            rresp = ($urandom_range(5, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            do_fetch(pc, ar_wait, r_wait, $urandom, rresp, ($urandom_range(7, 0) == 0));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef IFU_PERF_EN
        check("perf_fetch", 64'(perf_fetch_cnt), 64'(exp_fetch));
        check("perf_stall", 64'(perf_stall_cnt), 64'(exp_stall));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Watchdog: the sequence above is bounded, this only guards a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
